// File: rtl/reglk_wr_ctrl.sv
// Register-lock write controller: sticky lock entries, global lock, JTAG key-check unlock window.
// Optional fail counter / terminal lockout enabled by defining REGLK_LOCKOUT_EN.
module reglk_wr_ctrl #(
  parameter int          NUM_ENTRIES = 6,
  parameter logic [31:0] UNLOCK_KEY  = 32'hA5C3_0F1E,
  parameter int          UNLOCK_WIN  = 16,
  parameter int          MAX_FAILS   = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_low,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [2:0]                  addr_i,
  input  logic [31:0]                 wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o,
  input  logic                        jtag_unlock_i,
  input  logic [31:0]                 jtag_key_i,
  output logic [NUM_ENTRIES-1:0][31:0] reglk_mem_o,
  output logic                        unlocked_o,
  output logic                        lockout_o
);

  typedef enum logic [1:0] {IDLE, KEY_CHECK, UNLOCKED, LOCKOUT} state_e;

  state_e      state_q, state_d;
  logic [31:0] key_q, key_d;
  logic [7:0]  win_q, win_d;
  logic [NUM_ENTRIES-1:0][31:0] mem_q;

`ifdef REGLK_LOCKOUT_EN
  logic [2:0] fail_q, fail_d;
`else
  logic unused_max_fails;
  assign unused_max_fails = ^3'(MAX_FAILS);
`endif

  always_ff @(posedge clk_i or negedge rst_low) begin
    if (!rst_low) begin
      state_q <= IDLE;
      key_q   <= '0;
      win_q   <= '0;
`ifdef REGLK_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      win_q   <= win_d;
`ifdef REGLK_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    win_d   = win_q;
`ifdef REGLK_LOCKOUT_EN
    fail_d  = fail_q;
`endif
    case (state_q)
      IDLE: begin
        if (jtag_unlock_i) begin
          key_d   = jtag_key_i;
          state_d = KEY_CHECK;
        end
      end
      KEY_CHECK: begin
        if (key_q == UNLOCK_KEY) begin
          state_d = UNLOCKED;
          win_d   = 8'(UNLOCK_WIN);
`ifdef REGLK_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
`ifdef REGLK_LOCKOUT_EN
          fail_d  = fail_q + 3'd1;
          state_d = (fail_d == 3'(MAX_FAILS)) ? LOCKOUT : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      UNLOCKED: begin
        // Strobes are ignored here so a window can never be extended.
        win_d = win_q - 8'd1;
        if (win_q == 8'd1) state_d = IDLE;
      end
      LOCKOUT: ;
      default: state_d = IDLE;
    endcase
  end

  logic        unlocked, glb_lock, addr_ok, wr_en;
  logic [31:0] addr_ext, rd_data;

  assign unlocked = (state_q == UNLOCKED);
  assign glb_lock = mem_q[NUM_ENTRIES-1][31];
  assign addr_ext = 32'(addr_i);
  assign addr_ok  = addr_ext < NUM_ENTRIES;
  assign gnt_o    = req_i && (state_q != KEY_CHECK);
  assign wr_en    = gnt_o && we_i && addr_ok && (unlocked || !glb_lock);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (addr_ext == i) rd_data = mem_q[i];
  end

  // Inside the window entries are overwritten (clears allowed); otherwise bits only stick.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_low) begin
      if (!rst_low)                    mem_q[g] <= '0;
      else if (wr_en && addr_ext == g) mem_q[g] <= unlocked ? wdata_i : (mem_q[g] | wdata_i);
    end
  end

  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_low) begin
    if (!rst_low) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o;
      err_q    <= gnt_o && (!addr_ok || (we_i && !unlocked && glb_lock));
      rdata_q  <= (gnt_o && !we_i && addr_ok) ? rd_data : 32'd0;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign reglk_mem_o = mem_q;
  assign unlocked_o  = unlocked;
`ifdef REGLK_LOCKOUT_EN
  assign lockout_o   = (state_q == LOCKOUT);
`else
  assign lockout_o   = 1'b0;
`endif

endmodule
